// File: rtl/cmp_arb_pkg.sv
// Shared types and constants for the cmp_arb shared-comparator arbiter.
package cmp_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int unsigned N_REQ_DEFAULT = 4;
  localparam int unsigned PTR_W         = $clog2(N_REQ_DEFAULT);

  // Pointer/index width for a given requester count (never below one bit).
  function automatic int unsigned ptr_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cmp8.sv
// 8-bit unsigned magnitude comparator.
module cmp8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       gt,
  output logic       lt,
  output logic       eq
);

  assign gt = (a > b);
  assign lt = (a < b);
  assign eq = (a == b);

endmodule

// File: rtl/rr_arb.sv
// Combinational round-robin select: first set request at or after ptr.
module rr_arb #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IdxW  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IdxW-1:0]  ptr,
  output logic [N_REQ-1:0] grant_oh,
  output logic [IdxW-1:0]  grant_idx
);

  logic            found;
  logic [IdxW-1:0] idx;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    // N_REQ is a power of two, so the index add wraps on its own.
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = ptr + IdxW'(i);
      if (!found && req[idx]) begin
        found         = 1'b1;
        grant_idx     = idx;
        grant_oh[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cmp_arb.sv
// N_REQ requesters share one unsigned comparator through a round-robin arbiter.
module cmp_arb
  import cmp_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W     = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*W-1:0]          req_a,
  input  logic [N_REQ*W-1:0]          req_b,
  output logic [N_REQ-1:0]            req_ready,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [ptr_w(N_REQ)-1:0]     rsp_id,
  output logic                        rsp_gt,
  output logic                        rsp_lt,
  output logic                        rsp_eq,
  output logic                        busy
);

  localparam int unsigned IdxW = ptr_w(N_REQ);

  state_e          state_q, state_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] rsp_id_q, rsp_id_d;
  logic [W-1:0]    op_a_q, op_a_d;
  logic [W-1:0]    op_b_q, op_b_d;
  logic            gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            busy_q, busy_d;

  logic [N_REQ-1:0] grant_oh;
  logic [IdxW-1:0]  grant_idx;
  logic             cmp_gt, cmp_lt, cmp_eq;

  rr_arb #(
    .N_REQ (N_REQ),
    .IdxW  (IdxW)
  ) u_rr_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx)
  );

  if (W == 8) begin : g_cmp8
    cmp8 u_cmp8 (
      .a  (op_a_q),
      .b  (op_b_q),
      .gt (cmp_gt),
      .lt (cmp_lt),
      .eq (cmp_eq)
    );
  end else begin : g_cmp_inline
    assign cmp_gt = (op_a_q > op_b_q);
    assign cmp_lt = (op_a_q < op_b_q);
    assign cmp_eq = (op_a_q == op_b_q);
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rsp_id_d    = rsp_id_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    gt_d        = gt_q;
    lt_d        = lt_q;
    eq_d        = eq_q;
    rsp_valid_d = rsp_valid_q;
    busy_d      = busy_q;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          op_a_d   = req_a[grant_idx*W +: W];
          op_b_d   = req_b[grant_idx*W +: W];
          rsp_id_d = grant_idx;
          ptr_d    = grant_idx + IdxW'(1);
          state_d  = CMP;
          busy_d   = 1'b1;
        end
      end
      CMP: begin
        gt_d        = cmp_gt;
        lt_d        = cmp_lt;
        eq_d        = cmp_eq;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      rsp_id_q    <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      gt_q        <= 1'b0;
      lt_q        <= 1'b0;
      eq_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rsp_id_q    <= rsp_id_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      gt_q        <= gt_d;
      lt_q        <= lt_d;
      eq_q        <= eq_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  // The accept pulse is same-cycle by nature; rst_n gating keeps it low in reset.
  assign req_ready = (rst_n && state_q == IDLE) ? grant_oh : '0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_gt    = gt_q;
  assign rsp_lt    = lt_q;
  assign rsp_eq    = eq_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_cmp_arb.sv
// Directed and random checks of cmp_arb against a transaction-level reference model.
module tb_cmp_arb;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   req_ready;
  logic           rsp_valid, rsp_ready;
  logic [1:0]     rsp_id;
  logic           rsp_gt, rsp_lt, rsp_eq, busy;

  cmp_arb #(.N_REQ(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_gt    (rsp_gt),
    .rsp_lt    (rsp_lt),
    .rsp_eq    (rsp_eq),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Model: rotating pointer, age of the open transaction (0 = none) and its operands.
  int         m_ptr   = 0;
  int         m_age   = 0;
  int         m_id    = 0;
  logic [7:0] m_a, m_b;

  typedef struct {int id; logic gt; logic lt; logic eq;} rsp_t;
  int   grant_q[$];
  rsp_t rsp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int pick_grant();
    for (int i = 0; i < N; i++) begin
      if (req_valid[(m_ptr + i) % N]) return (m_ptr + i) % N;
    end
    return -1;
  endfunction

  task automatic check_and_step();
    int g;
    if (!rst_n) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_flags", {rsp_gt, rsp_lt, rsp_eq, rsp_id}, 0);
      m_ptr = 0;
      m_age = 0;
      return;
    end
    g = (m_age == 0) ? pick_grant() : -1;
    chk("req_ready", req_ready, (g >= 0) ? (32'd1 << g) : 32'd0);
    chk("busy", busy, m_age > 0);
    chk("rsp_valid", rsp_valid, m_age >= 2);
    if (m_age >= 2) begin
      chk("rsp_id", rsp_id, m_id);
      chk("rsp_gt", rsp_gt, m_a > m_b);
      chk("rsp_lt", rsp_lt, m_a < m_b);
      chk("rsp_eq", rsp_eq, m_a == m_b);
      if (rsp_ready) rsp_q.push_back('{int'(rsp_id), rsp_gt, rsp_lt, rsp_eq});
    end
    if (g >= 0) begin
      grant_q.push_back(g);
      m_id  = g;
      m_a   = req_a[g*W +: W];
      m_b   = req_b[g*W +: W];
      m_ptr = (g + 1) % N;
      m_age = 1;
    end else if (m_age >= 2 && rsp_ready) begin
      m_age = 0;
    end else if (m_age > 0) begin
      m_age++;
    end
  endtask

  // Sample at the falling edge, then return just after the next rising edge.
  task automatic cycle();
    @(negedge clk);
    check_and_step();
    @(posedge clk);
    #1;
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    chk("async_rsp_valid", rsp_valid, 0);
    chk("async_busy", busy, 0);
    chk("async_req_ready", req_ready, 0);
    chk("async_flags", {rsp_gt, rsp_lt, rsp_eq, rsp_id}, 0);
    m_ptr = 0;
    m_age = 0;
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic set_ops(input int r, input logic [7:0] a, input logic [7:0] b);
    req_a[r*W +: W] = a;
    req_b[r*W +: W] = b;
  endtask

  initial begin
    int exp_g[5];
    int exp_f[4];
    logic [2:0] f;
    rst_n     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) cycle();
    rst_n = 1'b1;

    // Idle after release.
    repeat (10) cycle();

    // Single request r0, 22 vs 12.
    set_ops(0, 8'd22, 8'd12);
    req_valid = 4'b0001;
    cycle();
    req_valid = '0;
    repeat (4) cycle();
    chk("single_grants", grant_q.size(), 1);
    chk("single_rsps", rsp_q.size(), 1);
    if (rsp_q.size() > 0) chk("single_gt", {rsp_q[0].gt, rsp_q[0].lt, rsp_q[0].eq}, 3'b100);
    grant_q.delete();
    rsp_q.delete();

    // Four continuous requesters from a fresh pointer.
    async_reset();
    set_ops(0, 8'd12, 8'd22);
    set_ops(1, 8'd22, 8'd22);
    set_ops(2, 8'd0, 8'd0);
    set_ops(3, 8'd255, 8'd0);
    req_valid = 4'b1111;
    repeat (14) cycle();
    req_valid = '0;
    repeat (3) cycle();
    exp_g = '{0, 1, 2, 3, 0};
    exp_f = '{3'b010, 3'b001, 3'b001, 3'b100};
    chk("rr_grant_cnt", grant_q.size(), 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("rr_grant%0d", i), (i < grant_q.size()) ? grant_q[i] : -1, exp_g[i]);
    for (int i = 0; i < 4; i++) begin
      f = (i < rsp_q.size()) ? {rsp_q[i].gt, rsp_q[i].lt, rsp_q[i].eq} : 3'b111;
      chk($sformatf("rr_flags%0d", i), f, exp_f[i]);
    end
    grant_q.delete();
    rsp_q.delete();

    // Consumer stalls for several RESP cycles while others wait.
    set_ops(2, 8'd5, 8'd9);
    req_valid = 4'b0100;
    rsp_ready = 1'b0;
    cycle();
    req_valid = 4'b1011;
    repeat (6) cycle();
    chk("stall_no_grant", grant_q.size(), 1);
    req_valid = '0;
    rsp_ready = 1'b1;
    cycle();
    chk("stall_rsps", rsp_q.size(), 1);
    if (rsp_q.size() > 0) chk("stall_id", rsp_q[0].id, 2);
    grant_q.delete();
    rsp_q.delete();

    // Reset in RESP with pointer at 3; afterwards r2 must beat r3.
    req_valid = 4'b0100;
    rsp_ready = 1'b0;
    cycle();
    req_valid = '0;
    repeat (2) cycle();
    chk("pre_reset_valid", rsp_valid, 1);
    async_reset();
    rsp_q.delete();
    grant_q.delete();
    req_valid = 4'b1100;
    rsp_ready = 1'b1;
    cycle();
    req_valid = '0;
    repeat (3) cycle();
    chk("post_reset_first", (grant_q.size() > 0) ? grant_q[0] : -1, 2);
    grant_q.delete();
    rsp_q.delete();

    // r1 withdraws before its grant.
    async_reset();
    set_ops(0, 8'd1, 8'd2);
    set_ops(1, 8'd3, 8'd3);
    set_ops(2, 8'd9, 8'd4);
    req_valid = 4'b0111;
    cycle();
    req_valid = 4'b0100;
    repeat (3) cycle();
    req_valid = '0;
    repeat (4) cycle();
    chk("drop_cnt", grant_q.size(), 2);
    chk("drop_second", (grant_q.size() > 1) ? grant_q[1] : -1, 2);
    for (int i = 0; i < rsp_q.size(); i++) chk("drop_no_r1", rsp_q[i].id != 1, 1);

    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 400; i++) begin
      req_valid = N'($urandom);
      req_a     = $urandom;
      req_b     = ($urandom_range(0, 2) == 0) ? req_a : $urandom;
      rsp_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) async_reset();
      else cycle();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/cmp_arb.md
CMP_ARB -- requirements
Module: cmp_arb

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of requesters sharing one comparator; it SHALL be a power of two, from 2 to 8.
REQ-002 Parameter W, default 8, SHALL set the operand width in bits.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port req_valid, input, N_REQ bits: per-requester request strobe.
REQ-006 Port req_a, input, N_REQ*W bits: operand A, packed; requester r occupies bits [r*W +: W].
REQ-007 Port req_b, input, N_REQ*W bits: operand B, packed the same way as req_a.
REQ-008 Port req_ready, output, N_REQ bits: one-hot, one-cycle operand-accept pulse.
REQ-009 Port rsp_valid, output, 1 bit: a result is available.
REQ-010 Port rsp_ready, input, 1 bit: the consumer accepts the result.
REQ-011 Port rsp_id, output, log2(N_REQ) bits: index of the requester that owns the result.
REQ-012 Ports rsp_gt, rsp_lt, rsp_eq, output, 1 bit each: A>B, A<B and A==B, unsigned.
REQ-013 Port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-014 The FSM SHALL have three states, IDLE, CMP and RESP, and SHALL be one-hot or binary-encoded.
REQ-015 IDLE, no bit of req_valid set: the FSM SHALL stay in IDLE and all req_ready bits SHALL be 0.
REQ-016 IDLE, any bit of req_valid set:
- the round-robin arbiter SHALL grant the first set bit at or after pointer ptr;
- req_ready[grant] SHALL be 1 in that same cycle;
- the granted operands SHALL be latched into op_a and op_b, the grant index into rsp_id;
- the FSM SHALL then go to CMP.
REQ-017 CMP: op_a and op_b SHALL be compared; gt/lt/eq SHALL be registered into rsp_gt/rsp_lt/rsp_eq; the FSM SHALL go to RESP.
REQ-018 RESP: rsp_valid SHALL be 1, and rsp_id and the flags SHALL be held stable until rsp_ready is sampled 1; then the FSM SHALL go to IDLE.
REQ-019 Exactly one of rsp_gt, rsp_lt, rsp_eq SHALL be 1 while rsp_valid is 1.
REQ-020 Latency SHALL be 2 cycles from the req_ready pulse to the first rsp_valid cycle; peak throughput SHALL be one compare per 3 cycles with rsp_ready tied to 1.
REQ-021 ptr SHALL load (grant+1) mod N_REQ on the grant cycle; the wrap from N_REQ-1 to 0 SHALL be natural.
REQ-022 A requester SHALL hold req_valid and its operands until its req_ready pulse; deasserting req_valid before its grant SHALL be legal and produce no response.
REQ-023 req_valid bits arriving during CMP or RESP SHALL NOT be granted until the next IDLE cycle.
REQ-024 A requester asserting req_valid again in the cycle after its own grant SHALL be treated as a new request.
REQ-025 If rsp_ready is already 1 on entry to RESP, rsp_valid SHALL last exactly one cycle.

Reset
REQ-026 Asserting rst_n low SHALL immediately force, without waiting for a clock edge:
- FSM to IDLE; ptr to 0;
- rsp_valid, rsp_gt, rsp_lt, rsp_eq, busy to 0;
- rsp_id, op_a, op_b to 0; req_ready to 0.
REQ-027 Reset asserted during CMP or RESP SHALL abandon the transaction; no response SHALL appear after release.
REQ-028 The first grant after rst_n deassertion SHALL be evaluated on the first rising edge with rst_n high.

Structure
REQ-029 A shared package cmp_arb_pkg SHALL hold the state encoding typedef and the constants IDLE, CMP, RESP and PTR_W = log2(N_REQ).
REQ-030 Arbitration SHALL be in one sub-module rr_arb, a combinational round-robin priority select with inputs req and ptr and outputs grant_oh and grant_idx.
REQ-031 The comparison SHALL use the codebase's existing 8-bit comparator for W = 8 and an equivalent inline compare otherwise.

Verification
REQ-032 Reset release, no requests for 10 cycles -> busy=0, rsp_valid=0, req_ready=0 throughout.
REQ-033 Single request, r0, A=22, B=12, rsp_ready=1 -> req_ready[0] pulse at cycle t; at t+2 rsp_valid=1, rsp_id=0, gt=1, lt=0, eq=0, for one cycle only.
REQ-034 All four requesters valid continuously, operands A=12/B=22 (r0), A=22/B=22 (r1), A=0/B=0 (r2), A=255/B=0 (r3) -> grant order 0,1,2,3,0; the flags for these requests SHALL be, in order, lt, eq, eq, gt.
REQ-035 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and the flags stable for 5 cycles, no req_ready pulses; the response completes on the first cycle rsp_ready=1.
REQ-036 rst_n pulsed low during RESP -> rsp_valid drops in the same cycle without a clock edge, ptr=0; after release, r2 and r3 both valid -> r2 granted first.
REQ-037 r1 drops req_valid before its grant, while r0 and r2 are valid -> grants go r0 then r2; no response ever carries rsp_id=1.
